stream_mask_generator: RTL and testbench

- Sequential, handshaked successor to the combinational byte-range mask generator.
- Accepts a request `(start lane, byte length)` and emits one `MASK_WIDTH`-bit lane-enable mask per beat until the byte range is covered, with first/last beat flags.
- Sits between header/offset parsing logic and the datapath stages that build `tkeep`/write-enable for multi-beat AXI-Stream packets.

---
 rtl/stream_mask_generator.sv | 89 ++++++++
 tb/tb_stream_mask_generator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/stream_mask_generator.sv
// stream_mask_generator: turns (start lane, byte length) requests into per-beat lane-enable masks with first/last flags
//   axis_aclk, axis_resetn : clock, async active-low reset
//   req_valid/req_ready    : request handshake; req_offset = first lane, req_length = byte count
//   mask_valid/mask_ready  : beat handshake; mask = lane enables, mask_first/mask_last = beat position
//   STREAM_MASK_GENERATOR_BACKTOBACK_EN : accept the next request on the last-beat handshake (no bubble)
module stream_mask_generator #(
  parameter int MASK_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  localparam int OFS_WIDTH = $clog2(MASK_WIDTH)
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OFS_WIDTH-1:0]  req_offset,
  input  logic [LEN_WIDTH-1:0]  req_length,
  output logic                  mask_valid,
  input  logic                  mask_ready,
  output logic [MASK_WIDTH-1:0] mask,
  output logic                  mask_first,
  output logic                  mask_last
);
  localparam int RW = LEN_WIDTH + 1;
  localparam logic [RW-1:0] MW_R = RW'(MASK_WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic live, take, beat_done, first_n, last_n;
  logic [RW-1:0] remaining, remaining_n, first_span, first_rem, next_rem;
  logic [MASK_WIDTH-1:0] mask_n, first_mask, next_mask;
  assign mask_valid = state == RUN;
  assign beat_done = mask_valid & mask_ready;
`ifdef STREAM_MASK_GENERATOR_BACKTOBACK_EN
  assign req_ready = live & ((state == IDLE) | (beat_done & mask_last));
`else
  assign req_ready = live & (state == IDLE);
`endif
  assign take = req_valid & req_ready;
  // remaining counts bytes still owed after the beat currently held in the output register
  assign first_span = MW_R - RW'(req_offset);
  assign first_rem = {1'b0, req_length} > first_span ? {1'b0, req_length} - first_span : '0;
  assign next_rem = remaining > MW_R ? remaining - MW_R : '0;
  always_comb begin
    first_mask = '0;
    next_mask = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      first_mask[i] = (i >= int'(req_offset)) && (i - int'(req_offset) < int'(req_length));
      next_mask[i] = i < int'(remaining);
    end
  end
  always_comb begin
    state_n = state;
    mask_n = mask;
    first_n = mask_first;
    last_n = mask_last;
    remaining_n = remaining;
    if (beat_done) begin
      state_n = mask_last ? IDLE : RUN;
      mask_n = next_mask;
      first_n = 1'b0;
      last_n = !mask_last && (next_rem == '0);
      remaining_n = next_rem;
    end
    if (take) begin
      state_n = RUN;
      mask_n = first_mask;
      first_n = 1'b1;
      last_n = first_rem == '0;
      remaining_n = first_rem;
    end
  end
  // live holds req_ready low until the first clock after reset release
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state <= IDLE;
      live <= 1'b0;
      mask <= '0;
      mask_first <= 1'b0;
      mask_last <= 1'b0;
      remaining <= '0;
    end else begin
      state <= state_n;
      live <= 1'b1;
      mask <= mask_n;
      mask_first <= first_n;
      mask_last <= last_n;
      remaining <= remaining_n;
    end
  end
endmodule

// File: tb/tb_stream_mask_generator.sv
// tb_stream_mask_generator: scoreboard bench for stream_mask_generator with a lane-position reference model
module tb_stream_mask_generator;
  localparam int MW = 32;
  localparam int LW = 16;
  logic clk = 0;
  logic axis_resetn = 0;
  logic req_valid = 0;
  logic req_ready;
  logic [4:0] req_offset = '0;
  logic [LW-1:0] req_length = '0;
  logic mask_valid;
  logic mask_ready = 0;
  logic [MW-1:0] mask;
  logic mask_first, mask_last;
  typedef struct packed {logic [MW-1:0] m; logic f; logic l;} beat_t;
  beat_t q[$];
  int total = 0;
  int bad = 0;
  int rdy_mode = 0;
  stream_mask_generator #(.MASK_WIDTH(MW), .LEN_WIDTH(LW)) dut (
    .axis_aclk(clk), .axis_resetn(axis_resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_offset(req_offset), .req_length(req_length),
    .mask_valid(mask_valid), .mask_ready(mask_ready),
    .mask(mask), .mask_first(mask_first), .mask_last(mask_last)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: beat b covers absolute byte positions b*MW .. b*MW+MW-1; a lane is set when its position lies in [ofs, ofs+len)
  task automatic push_req(int ofs, int len);
    int nb;
    beat_t e;
    nb = (len == 0) ? 1 : (ofs + len + MW - 1) / MW;
    for (int b = 0; b < nb; b++) begin
      e.m = '0;
      for (int i = 0; i < MW; i++) begin
        int p;
        p = b * MW + i;
        if (p >= ofs && p < ofs + len) e.m[i] = 1'b1;
      end
      e.f = b == 0;
      e.l = b == nb - 1;
      q.push_back(e);
    end
  endtask
  // caller sits just after a rising edge; returns just after the accepting edge
  task automatic send(int ofs, int len);
    int n;
    req_valid = 1;
    req_offset = 5'(ofs);
    req_length = LW'(len);
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        push_req(ofs, len);
        break;
      end
      if (++n > 3000) begin
        check("req_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 0;
    req_offset = 5'($urandom);
    req_length = LW'($urandom);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || mask_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n < 3000), 1);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    mask_ready = rdy_mode == 1 ? ($urandom % 3 != 0) : (rdy_mode == 0);
  end
  logic hold_prev = 0;
  logic after_last = 0;
  logic exp_gap = 0;
  logic [MW+2:0] held;
  always @(negedge clk) begin
    if (!axis_resetn) begin
      check("reset_out", {req_ready, mask_valid, mask, mask_first, mask_last}, 0);
      hold_prev <= 0;
      after_last <= 0;
    end else begin
      if (after_last) check("gap", mask_valid, exp_gap);
      if (hold_prev) check("hold", {mask_valid, mask, mask_first, mask_last}, held);
`ifdef STREAM_MASK_GENERATOR_BACKTOBACK_EN
      check("req_ready", req_ready, !mask_valid | (mask_ready & mask_last));
`else
      check("req_ready", req_ready, !mask_valid);
`endif
      if (mask_valid && mask_ready) begin
        if (q.size() == 0) check("extra_beat", 1, 0);
        else begin
          beat_t e;
          e = q.pop_front();
          check("beat", {mask, mask_first, mask_last}, {e.m, e.f, e.l});
        end
      end
      hold_prev <= mask_valid & !mask_ready;
      held <= {mask_valid, mask, mask_first, mask_last};
      after_last <= mask_valid & mask_ready & mask_last;
`ifdef STREAM_MASK_GENERATOR_BACKTOBACK_EN
      exp_gap <= req_valid & req_ready;
`else
      exp_gap <= 0;
`endif
    end
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1 axis_resetn = 1;
    @(posedge clk);
    #1;
    send(0, 32);
    drain();
    @(posedge clk);
    #1;
    send(4, 8);
    send(7, 0);
    drain();
    @(posedge clk);
    #1;
    send(30, 37);
    send(0, 64);
    send(31, 1);
    send(0, 33);
    drain();
    @(posedge clk);
    #1;
    send(30, 37);
    @(negedge clk);
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mask_valid && mask_last) && n < 50);
    check("beat3_timeout", 64'(n < 50), 1);
    #1 axis_resetn = 0;
    q.delete();
    repeat (2) @(negedge clk);
    #1 axis_resetn = 1;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_idle", {mask_valid, req_ready}, 2'b01);
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    for (int k = 0; k < 60; k++) begin
      int ofs, len;
      ofs = (k % 7 == 0) ? MW - 1 : int'($urandom_range(0, MW - 1));
      len = (k % 11 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 150));
      if (k == 30) len = 1000;
      send(ofs, len);
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
